// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Hazard and forwarding controller for the RV32I pipeline. A DEPTH-entry
//   scoreboard shadows the post-ID pipeline registers (stage 1 = EX ...
//   stage DEPTH = WB). From it and the instruction in ID the unit produces
//   operand forwarding selects, load-use stalls with bubble insertion,
//   branch/jump flushes and a global freeze while either cache is not ready.
//   Two saturating counters record load-use stall cycles and flush events.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   id_valid                 ID holds a real instruction
//   id_rs1/id_rs2            ID source register indices
//   id_uses_rs1/id_uses_rs2  ID actually reads the source
//   id_rd/id_we/id_is_load   ID destination, write enable, load flag
//   ex_br_taken              EX redirects the PC
//   imem_ready/dmem_ready    cache readiness (either low -> freeze)
//   perf_clr                 synchronous clear of both counters
//   freeze                   hold all pipeline registers and the PC
//   stall_if/stall_id        hold PC / IF-ID register
//   flush_if_id/flush_id_ex  turn the register into a bubble
//   fwd_a_sel/fwd_b_sel      0 = regfile, k = stage k result
//   stall_count/flush_count  saturating event counters
module pipe_hazard_unit #(
  parameter int DEPTH      = 3,
  parameter int REG_W      = 5,
  parameter bit WRITE_THRU = 1'b1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             perf_clr,
  output logic             freeze,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ACT_SHIFT,
    ACT_STALL,
    ACT_FLUSH,
    ACT_FREEZE
  } action_e;

  logic [DEPTH:1]   sb_valid;
  logic [DEPTH:1]   sb_we;
  logic [DEPTH:1]   sb_ld;
  logic [REG_W-1:0] sb_rd [1:DEPTH];

  logic [DEPTH:1]   match_a;
  logic [DEPTH:1]   match_b;
  logic             load_use;
  logic             cache_wait;
  action_e          act;

  // Per-stage source matches; x0 is never a producer.
  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      match_a[k] = sb_valid[k] && sb_we[k] && (sb_rd[k] != '0) &&
                   id_valid && id_uses_rs1 && (sb_rd[k] == id_rs1);
      match_b[k] = sb_valid[k] && sb_we[k] && (sb_rd[k] != '0) &&
                   id_valid && id_uses_rs2 && (sb_rd[k] == id_rs2);
    end
  end

  // Scan oldest to youngest so the youngest matching producer is left in
  // the select. A WB-only match reads the regfile when it writes through.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (match_a[k]) fwd_a_sel = SEL_W'(k);
      if (match_b[k]) fwd_b_sel = SEL_W'(k);
    end
    if (WRITE_THRU && (fwd_a_sel == SEL_W'(DEPTH))) fwd_a_sel = '0;
    if (WRITE_THRU && (fwd_b_sel == SEL_W'(DEPTH))) fwd_b_sel = '0;
  end

  assign load_use   = (match_a[1] || match_b[1]) && sb_ld[1];
  assign cache_wait = !imem_ready || !dmem_ready;

  always_comb begin
    act = ACT_SHIFT;
    if (cache_wait)       act = ACT_FREEZE;
    else if (ex_br_taken) act = ACT_FLUSH;
    else if (load_use)    act = ACT_STALL;
  end

  // Control outputs are held low while reset is asserted so that a reset
  // arriving mid-operation never emits a flush or stall pulse.
  always_comb begin
    freeze      = cache_wait;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst) begin
      unique case (act)
        ACT_FREEZE: begin
          stall_if = 1'b1;
          stall_id = 1'b1;
        end
        ACT_FLUSH: begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
        ACT_STALL: begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          flush_id_ex = 1'b1;
        end
        ACT_SHIFT: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid <= '0;
      sb_we    <= '0;
      sb_ld    <= '0;
      for (int unsigned k = 1; k <= DEPTH; k++) sb_rd[k] <= '0;
    end else if (act != ACT_FREEZE) begin
      for (int unsigned k = DEPTH; k >= 2; k--) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_we[k]    <= sb_we[k-1];
        sb_ld[k]    <= sb_ld[k-1];
        sb_rd[k]    <= sb_rd[k-1];
      end
      sb_valid[1] <= (act == ACT_SHIFT) && id_valid;
      sb_we[1]    <= (act == ACT_SHIFT) && id_we;
      sb_ld[1]    <= (act == ACT_SHIFT) && id_is_load;
      sb_rd[1]    <= (act == ACT_SHIFT) ? id_rd : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (perf_clr)
        stall_count <= '0;
      else if ((act == ACT_STALL) && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);

      if (perf_clr)
        flush_count <= '0;
      else if ((act == ACT_FLUSH) && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
module tb_pipe_hazard_unit;

  localparam int DEPTH = 3;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam bit WT    = 1'b1;
  localparam int SEL_W = $clog2(DEPTH + 1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_rs1 = '0;
  logic [REG_W-1:0] id_rs2 = '0;
  logic             id_uses_rs1 = 1'b0;
  logic             id_uses_rs2 = 1'b0;
  logic [REG_W-1:0] id_rd = '0;
  logic             id_we = 1'b0;
  logic             id_is_load = 1'b0;
  logic             ex_br_taken = 1'b0;
  logic             imem_ready = 1'b1;
  logic             dmem_ready = 1'b1;
  logic             perf_clr = 1'b0;
  logic             freeze, stall_if, stall_id, flush_if_id, flush_id_ex;
  logic [SEL_W-1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipe_hazard_unit #(
    .DEPTH(DEPTH), .REG_W(REG_W), .WRITE_THRU(WT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_we(id_we), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
    .freeze(freeze), .stall_if(stall_if), .stall_id(stall_id),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: list of in-flight instructions, youngest first.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       we;
    bit       ld;
  } ent_t;

  ent_t pipe[$];
  int   m_sc, m_fc;
  bit   m_frz, m_br, m_stl;

  function automatic void model_reset();
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back('{1'b0, 5'd0, 1'b0, 1'b0});
    m_sc = 0;
    m_fc = 0;
  endfunction

  function automatic bit hits(int i, logic [4:0] s, logic u);
    return id_valid && u && pipe[i].v && pipe[i].we && (pipe[i].rd != 0) && (pipe[i].rd == s);
  endfunction

  function automatic int exp_sel(logic [4:0] s, logic u);
    for (int i = 0; i < DEPTH; i++)
      if (hits(i, s, u)) return (WT && (i + 1 == DEPTH)) ? 0 : i + 1;
    return 0;
  endfunction

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic we, input logic ld, input logic br,
                        input logic im, input logic dm, input logic clr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_we = we; id_is_load = ld; ex_br_taken = br;
    imem_ready = im; dmem_ready = dm; perf_clr = clr;
  endtask

  // Compare all outputs against the model at the falling edge.
  task automatic eval(input string tag);
    bit lu;
    @(negedge clk);
    m_frz = !imem_ready || !dmem_ready;
    m_br  = !m_frz && ex_br_taken;
    lu    = (hits(0, id_rs1, id_uses_rs1) || hits(0, id_rs2, id_uses_rs2)) && pipe[0].ld;
    m_stl = !m_frz && !m_br && lu;
    chk({tag, ".freeze"},   freeze,      m_frz);
    chk({tag, ".stall_if"}, stall_if,    m_frz || m_stl);
    chk({tag, ".stall_id"}, stall_id,    m_frz || m_stl);
    chk({tag, ".fl_if_id"}, flush_if_id, m_br);
    chk({tag, ".fl_id_ex"}, flush_id_ex, m_br || m_stl);
    chk({tag, ".fwd_a"},    fwd_a_sel,   exp_sel(id_rs1, id_uses_rs1));
    chk({tag, ".fwd_b"},    fwd_b_sel,   exp_sel(id_rs2, id_uses_rs2));
    chk({tag, ".st_cnt"},   stall_count, m_sc);
    chk({tag, ".fl_cnt"},   flush_count, m_fc);
  endtask

  task automatic tick();
    if (perf_clr) m_sc = 0; else if (m_stl && m_sc < CMAX) m_sc++;
    if (perf_clr) m_fc = 0; else if (m_br && m_fc < CMAX) m_fc++;
    if (!m_frz) begin
      if (m_br || m_stl) pipe.push_front('{1'b0, 5'd0, 1'b0, 1'b0});
      else pipe.push_front('{id_valid, id_rd, id_we, id_is_load});
      void'(pipe.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic v; logic [4:0] rs1, rs2; logic u1, u2; logic [4:0] rd; logic we, ld, br, im, dm, clr;
    logic frz, sif, sid, fif, fix; int fa, fb, sc, fc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Reset state with a real instruction already in ID.
    set_in(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
    #3;
    chk("rst.freeze", freeze, 0);
    chk("rst.stall_if", stall_if, 0);
    chk("rst.flush", {flush_if_id, flush_id_ex}, 0);
    chk("rst.fwd_a", fwd_a_sel, 0);
    chk("rst.counts", {stall_count, flush_count}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    //            v rs1 rs2 u1 u2 rd we ld br im dm clr  frz sif sid fif fix fa fb sc fc
    tbl.push_back('{1, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0}); // addi x1
    tbl.push_back('{1, 1, 1, 1, 1, 2, 1, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1, 1, 0, 0}); // add x2,x1,x1
    tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 2, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0}); // x1 in WB
    tbl.push_back('{1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0}); // lw x5
    tbl.push_back('{1, 0, 5, 0, 1, 8, 1, 0, 0, 1, 1, 0,  0, 1, 1, 0, 1, 0, 1, 0, 0}); // load-use
    tbl.push_back('{1, 0, 5, 0, 1, 8, 1, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 2, 1, 0}); // retry
    tbl.push_back('{1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0}); // writes x0
    tbl.push_back('{1, 0, 8, 1, 1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 2, 1, 0}); // reads x0,x8
    tbl.push_back('{1, 0, 0, 0, 0, 6, 1, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0}); // lw x6
    tbl.push_back('{1, 6, 0, 1, 0, 9, 1, 0, 1, 1, 1, 0,  0, 0, 0, 1, 1, 1, 0, 1, 0}); // br + lu
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1}); // clear
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      set_in(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
             tbl[i].we, tbl[i].ld, tbl[i].br, tbl[i].im, tbl[i].dm, tbl[i].clr);
      @(negedge clk);
      chk({t, ".freeze"},   freeze,      tbl[i].frz);
      chk({t, ".stall_if"}, stall_if,    tbl[i].sif);
      chk({t, ".stall_id"}, stall_id,    tbl[i].sid);
      chk({t, ".fl_if_id"}, flush_if_id, tbl[i].fif);
      chk({t, ".fl_id_ex"}, flush_id_ex, tbl[i].fix);
      chk({t, ".fwd_a"},    fwd_a_sel,   tbl[i].fa);
      chk({t, ".fwd_b"},    fwd_b_sel,   tbl[i].fb);
      chk({t, ".st_cnt"},   stall_count, tbl[i].sc);
      chk({t, ".fl_cnt"},   flush_count, tbl[i].fc);
      @(posedge clk);
      #1;
    end

    // Freeze holds a pending branch and the scoreboard.
    reset_all();
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 1, 0);
    eval("frz.prod"); tick();
    for (int c = 0; c < 3; c++) begin
      set_in(1, 7, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
      eval("frz.hold");
      chk("frz.freeze", freeze, 1);
      chk("frz.noflush", flush_if_id, 0);
      chk("frz.sb_held", fwd_a_sel, 1);
      tick();
    end
    set_in(1, 7, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0);
    eval("frz.release");
    chk("frz.flush4", flush_if_id, 1);
    chk("frz.fwd4", fwd_a_sel, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    eval("frz.after");
    chk("frz.flcnt", flush_count, 1);
    tick();

    // Stall counter saturation, then clear winning over a stall.
    reset_all();
    for (int n = 0; n < (1 << CNT_W) + 5; n++) begin
      set_in(1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 1, 0);
      eval("sat.lw"); tick();
      set_in(1, 0, 5, 0, 1, 9, 1, 0, 0, 1, 1, 0);
      eval("sat.use"); tick();
    end
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 1, 0);
    eval("sat.lw2");
    chk("sat.max", stall_count, CMAX);
    tick();
    set_in(1, 0, 5, 0, 1, 9, 1, 0, 0, 1, 1, 1);
    eval("sat.clr");
    chk("sat.clr_stall", stall_if, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    eval("sat.after");
    chk("sat.zero", stall_count, 0);
    tick();

    // Randomized run with a mid-stream asynchronous reset.
    reset_all();
    for (int c = 0; c < 1500; c++) begin
      set_in(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0),
             ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 40) == 0));
      if (c == 700) begin
        #2;
        rst = 1'b0;
        #1;
        chk("mid.fwd", {fwd_a_sel, fwd_b_sel}, 0);
        chk("mid.counts", {stall_count, flush_count}, 0);
        chk("mid.flush", {flush_if_id, flush_id_ex}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
      end else begin
        eval("rnd");
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
